id_ex_stage: RTL and testbench

- ID/EX pipeline register directly downstream of the register file in the 5-stage MIPS pipeline.
- Captures the decoded instruction fields and the two register-file read operands, and presents them to EX.
- Bypasses a same-cycle writeback into the captured operands, because the register file writes on the clock edge and reads combinationally.
- Supports stall (hold), flush (bubble) and saturating stall/flush event counters for debug.

---
 rtl/id_ex_if.sv | 16 +
 rtl/id_ex_stage.sv | 115 +++++++++++
 tb/tb_id_ex_stage.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/id_ex_if.sv
// Decoded-instruction bundle handed from the ID stage to the ID/EX pipeline register.
interface id_ex_if #(
   parameter int CTRL_W = 12
);
   logic              id_valid;
   logic [31:0]       id_pc;
   logic [4:0]        id_rs;
   logic [4:0]        id_rt;
   logic [4:0]        id_rd;
   logic [4:0]        id_shamt;
   logic [31:0]       id_imm;
   logic [CTRL_W-1:0] id_ctrl;

   modport master (output id_valid, id_pc, id_rs, id_rt, id_rd, id_shamt, id_imm, id_ctrl);
   modport slave  (input  id_valid, id_pc, id_rs, id_rt, id_rd, id_shamt, id_imm, id_ctrl);
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with same-cycle writeback bypass, stall/flush control
// and saturating debug counters for stall and flush events.
module id_ex_stage #(
   parameter int CTRL_W        = 12,
   parameter int CNT_W         = 16,
   parameter int ZERO_REG_HARD = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              stall,
   input  logic              flush,
   id_ex_if.slave            id,
   input  logic [31:0]       rf_data1,
   input  logic [31:0]       rf_data2,
   input  logic              wb_write,
   input  logic [4:0]        wb_reg,
   input  logic [31:0]       wb_data,
   output logic              ex_valid,
   output logic [31:0]       ex_pc,
   output logic [4:0]        ex_rs,
   output logic [4:0]        ex_rt,
   output logic [4:0]        ex_rd,
   output logic [4:0]        ex_shamt,
   output logic [31:0]       ex_imm,
   output logic [CTRL_W-1:0] ex_ctrl,
   output logic [31:0]       ex_a,
   output logic [31:0]       ex_b,
   output logic [CNT_W-1:0]  stall_cnt,
   output logic [CNT_W-1:0]  flush_cnt
);

   logic [31:0] byp_a;
   logic [31:0] byp_b;
   logic        bubble;

   function automatic logic is_zero_reg(input logic [4:0] r);
      return (ZERO_REG_HARD != 0) && (r == 5'd0);
   endfunction

   function automatic logic wb_hit(input logic [4:0] r);
      return wb_write && (wb_reg == r) && !is_zero_reg(r);
   endfunction

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
      return (&c) ? c : c + CNT_W'(1);
   endfunction

   // ID side: register-file read with writeback forwarding
   always_comb begin
      byp_a = rf_data1;
      byp_b = rf_data2;
      if (is_zero_reg(id.id_rs))  byp_a = '0;
      else if (wb_hit(id.id_rs))  byp_a = wb_data;
      if (is_zero_reg(id.id_rt))  byp_b = '0;
      else if (wb_hit(id.id_rt))  byp_b = wb_data;
   end

   // A load with no real instruction behaves as a bubble, but is not counted as a flush
   assign bubble = flush || (!stall && !id.id_valid);

   // EX side: pipeline register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ex_valid <= 1'b0;
         ex_pc    <= '0;
         ex_rs    <= '0;
         ex_rt    <= '0;
         ex_rd    <= '0;
         ex_shamt <= '0;
         ex_imm   <= '0;
         ex_ctrl  <= '0;
         ex_a     <= '0;
         ex_b     <= '0;
      end else if (bubble) begin
         ex_valid <= 1'b0;
         ex_pc    <= '0;
         ex_rs    <= '0;
         ex_rt    <= '0;
         ex_rd    <= '0;
         ex_shamt <= '0;
         ex_imm   <= '0;
         ex_ctrl  <= '0;
         ex_a     <= '0;
         ex_b     <= '0;
      end else if (stall) begin
         // A held instruction must still see writebacks that land while it waits
         if (ex_valid && wb_hit(ex_rs)) ex_a <= wb_data;
         if (ex_valid && wb_hit(ex_rt)) ex_b <= wb_data;
      end else begin
         ex_valid <= 1'b1;
         ex_pc    <= id.id_pc;
         ex_rs    <= id.id_rs;
         ex_rt    <= id.id_rt;
         ex_rd    <= id.id_rd;
         ex_shamt <= id.id_shamt;
         ex_imm   <= id.id_imm;
         ex_ctrl  <= id.id_ctrl;
         ex_a     <= byp_a;
         ex_b     <= byp_b;
      end
   end

   // Debug event counters
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else if (flush) begin
         flush_cnt <= sat_inc(flush_cnt);
      end else if (stall) begin
         stall_cnt <= sat_inc(stall_cnt);
      end
   end

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: three parameter variants share one stimulus and are
// checked every cycle against a transaction-level model, plus hand-computed spot checks.
module tb_id_ex_stage;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        stall = 1'b0, flush = 1'b0;
   logic [31:0] rf_data1 = '0, rf_data2 = '0, wb_data = '0;
   logic        wb_write = 1'b0;
   logic [4:0]  wb_reg = '0;

   int n_tests = 0;
   int n_fail  = 0;

   id_ex_if #(.CTRL_W(12)) idb ();

   // variant m: defaults; variant z: ZERO_REG_HARD=0; variant s: CNT_W=4
   logic        v_m, v_z, v_s;
   logic [31:0] pc_m, pc_z, pc_s, imm_m, imm_z, imm_s, a_m, a_z, a_s, b_m, b_z, b_s;
   logic [4:0]  rs_m, rs_z, rs_s, rt_m, rt_z, rt_s, rd_m, rd_z, rd_s, sh_m, sh_z, sh_s;
   logic [11:0] c_m, c_z, c_s;
   logic [15:0] sc_m, fc_m, sc_z, fc_z;
   logic [3:0]  sc_s, fc_s;

   id_ex_stage #(.CTRL_W(12), .CNT_W(16), .ZERO_REG_HARD(1)) dut_m (
      .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush), .id(idb),
      .rf_data1(rf_data1), .rf_data2(rf_data2), .wb_write(wb_write), .wb_reg(wb_reg), .wb_data(wb_data),
      .ex_valid(v_m), .ex_pc(pc_m), .ex_rs(rs_m), .ex_rt(rt_m), .ex_rd(rd_m), .ex_shamt(sh_m),
      .ex_imm(imm_m), .ex_ctrl(c_m), .ex_a(a_m), .ex_b(b_m), .stall_cnt(sc_m), .flush_cnt(fc_m));

   id_ex_stage #(.CTRL_W(12), .CNT_W(16), .ZERO_REG_HARD(0)) dut_z (
      .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush), .id(idb),
      .rf_data1(rf_data1), .rf_data2(rf_data2), .wb_write(wb_write), .wb_reg(wb_reg), .wb_data(wb_data),
      .ex_valid(v_z), .ex_pc(pc_z), .ex_rs(rs_z), .ex_rt(rt_z), .ex_rd(rd_z), .ex_shamt(sh_z),
      .ex_imm(imm_z), .ex_ctrl(c_z), .ex_a(a_z), .ex_b(b_z), .stall_cnt(sc_z), .flush_cnt(fc_z));

   id_ex_stage #(.CTRL_W(12), .CNT_W(4), .ZERO_REG_HARD(1)) dut_s (
      .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush), .id(idb),
      .rf_data1(rf_data1), .rf_data2(rf_data2), .wb_write(wb_write), .wb_reg(wb_reg), .wb_data(wb_data),
      .ex_valid(v_s), .ex_pc(pc_s), .ex_rs(rs_s), .ex_rt(rt_s), .ex_rd(rd_s), .ex_shamt(sh_s),
      .ex_imm(imm_s), .ex_ctrl(c_s), .ex_a(a_s), .ex_b(b_s), .stall_cnt(sc_s), .flush_cnt(fc_s));

   always #5 clk = ~clk;

   // ---------------- behavioural model ----------------
   typedef struct {
      bit          valid;
      logic [31:0] pc, imm, a, b;
      logic [4:0]  rs, rt, rd, sh;
      logic [11:0] ctrl;
      int          scnt, fcnt;
   } ex_t;

   ex_t mm, mz, ms;

   function automatic ex_t empty_ex(input int scnt, input int fcnt);
      ex_t e;
      e.valid = 0; e.pc = '0; e.imm = '0; e.a = '0; e.b = '0;
      e.rs = '0; e.rt = '0; e.rd = '0; e.sh = '0; e.ctrl = '0;
      e.scnt = scnt; e.fcnt = fcnt;
      return e;
   endfunction

   // Value architecturally seen for register r this cycle, given the writeback in flight
   function automatic logic [31:0] reg_val(input logic [4:0] r, input logic [31:0] rf, input bit zh);
      if (zh && r == 0) return 32'd0;
      if (wb_write && wb_reg == r) return wb_data;
      return rf;
   endfunction

   function automatic ex_t next_ex(input ex_t s, input bit zh, input int cmax);
      ex_t n;
      n = s;
      if (flush) begin
         n = empty_ex(s.scnt, (s.fcnt < cmax) ? s.fcnt + 1 : cmax);
      end else if (stall) begin
         if (s.valid && !(zh && s.rs == 0)) n.a = reg_val(s.rs, s.a, zh);
         if (s.valid && !(zh && s.rt == 0)) n.b = reg_val(s.rt, s.b, zh);
         n.scnt = (s.scnt < cmax) ? s.scnt + 1 : cmax;
      end else if (!idb.id_valid) begin
         n = empty_ex(s.scnt, s.fcnt);
      end else begin
         n.valid = 1; n.pc = idb.id_pc; n.imm = idb.id_imm; n.ctrl = idb.id_ctrl;
         n.rs = idb.id_rs; n.rt = idb.id_rt; n.rd = idb.id_rd; n.sh = idb.id_shamt;
         n.a = reg_val(idb.id_rs, rf_data1, zh);
         n.b = reg_val(idb.id_rt, rf_data2, zh);
      end
      return n;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mm = empty_ex(0, 0); mz = empty_ex(0, 0); ms = empty_ex(0, 0);
      end else begin
         mm = next_ex(mm, 1'b1, 65535);
         mz = next_ex(mz, 1'b0, 65535);
         ms = next_ex(ms, 1'b1, 15);
      end
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
      end
   endtask

   task automatic chk_var(input string tag, input logic v, input logic [31:0] pc, input logic [4:0] rs,
                          input logic [4:0] rt, input logic [4:0] rd, input logic [4:0] sh,
                          input logic [31:0] imm, input logic [11:0] c, input logic [31:0] a,
                          input logic [31:0] b, input logic [15:0] sc, input logic [15:0] fc, input ex_t e);
      chk({tag, ".ex_valid"}, 64'(v), 64'(e.valid));
      chk({tag, ".ex_pc"}, 64'(pc), 64'(e.pc));
      chk({tag, ".ex_rs"}, 64'(rs), 64'(e.rs));
      chk({tag, ".ex_rt"}, 64'(rt), 64'(e.rt));
      chk({tag, ".ex_rd"}, 64'(rd), 64'(e.rd));
      chk({tag, ".ex_shamt"}, 64'(sh), 64'(e.sh));
      chk({tag, ".ex_imm"}, 64'(imm), 64'(e.imm));
      chk({tag, ".ex_ctrl"}, 64'(c), 64'(e.ctrl));
      chk({tag, ".ex_a"}, 64'(a), 64'(e.a));
      chk({tag, ".ex_b"}, 64'(b), 64'(e.b));
      chk({tag, ".stall_cnt"}, 64'(sc), 64'(e.scnt));
      chk({tag, ".flush_cnt"}, 64'(fc), 64'(e.fcnt));
   endtask

   // Per-cycle comparison, away from the active edge
   always @(negedge clk) begin
      chk_var("m", v_m, pc_m, rs_m, rt_m, rd_m, sh_m, imm_m, c_m, a_m, b_m, sc_m, fc_m, mm);
      chk_var("z", v_z, pc_z, rs_z, rt_z, rd_z, sh_z, imm_z, c_z, a_z, b_z, sc_z, fc_z, mz);
      chk_var("s", v_s, pc_s, rs_s, rt_s, rd_s, sh_s, imm_s, c_s, a_s, b_s, 16'(sc_s), 16'(fc_s), ms);
   end

   // ---------------- directed stimulus ----------------
   task automatic cyc();
      @(posedge clk);
      #2;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      #1;
      rst_n = 1'b1;
   endtask

   initial begin
      idb.id_valid = 1'b0; idb.id_pc = '0; idb.id_rs = '0; idb.id_rt = '0;
      idb.id_rd = '0; idb.id_shamt = '0; idb.id_imm = '0; idb.id_ctrl = '0;
      #1 rst_n = 1'b0;
      cyc(); cyc();
      chk("reset ex_valid", 64'(v_m), 64'd0);
      chk("reset ex_a", 64'(a_m), 64'd0);
      chk("reset stall_cnt", 64'(sc_m), 64'd0);
      rst_n = 1'b1;

      // Reset mid-operation
      idb.id_valid = 1'b1; idb.id_pc = 32'h40; idb.id_rs = 5'd1; idb.id_rt = 5'd2;
      idb.id_rd = 5'd3; idb.id_shamt = 5'd4; idb.id_imm = 32'hFFFF_FF80; idb.id_ctrl = 12'h5A5;
      rf_data1 = 32'd20; rf_data2 = 32'd30;
      cyc();
      chk("load ex_pc", 64'(pc_m), 64'h40);
      chk("load ex_a", 64'(a_m), 64'd20);
      #1 rst_n = 1'b0;
      #1;
      chk("async reset ex_pc", 64'(pc_m), 64'd0);
      chk("async reset ex_a", 64'(a_m), 64'd0);
      chk("async reset ex_ctrl", 64'(c_m), 64'd0);
      rst_n = 1'b1;
      cyc();
      chk("post-reset ex_a", 64'(a_m), 64'd20);
      chk("post-reset ex_valid", 64'(v_m), 64'd1);

      // Same-cycle bypass on rs only
      idb.id_rs = 5'd3; idb.id_rt = 5'd2; rf_data1 = 32'd10; rf_data2 = 32'd45;
      wb_write = 1'b1; wb_reg = 5'd3; wb_data = 32'h99;
      cyc();
      chk("bypass ex_a", 64'(a_m), 64'h99);
      chk("no-bypass ex_b", 64'(b_m), 64'd45);

      // Register zero: hard-wired vs ordinary
      idb.id_rs = 5'd0; rf_data1 = 32'd10; wb_reg = 5'd0; wb_data = 32'd7;
      cyc();
      chk("zero-hard ex_a", 64'(a_m), 64'd0);
      chk("zero-soft ex_a", 64'(a_z), 64'd7);

      // rs == rt share the bypass
      idb.id_rs = 5'd7; idb.id_rt = 5'd7; rf_data1 = 32'd1; rf_data2 = 32'd1;
      wb_reg = 5'd7; wb_data = 32'h1234;
      cyc();
      chk("same-reg ex_a", 64'(a_m), 64'h1234);
      chk("same-reg ex_b", 64'(b_m), 64'h1234);

      // Stall with refresh-on-hold
      wb_write = 1'b0;
      do_reset();
      idb.id_valid = 1'b1; idb.id_pc = 32'h100; idb.id_rs = 5'd5; idb.id_rt = 5'd4;
      idb.id_rd = 5'd9; idb.id_shamt = 5'd3; idb.id_imm = 32'hFFFF_FFF0; idb.id_ctrl = 12'hABC;
      rf_data1 = 32'd11; rf_data2 = 32'd6;
      cyc();
      chk("pre-stall ex_b", 64'(b_m), 64'd6);
      stall = 1'b1; idb.id_pc = 32'hDEAD; rf_data2 = 32'h77;
      cyc();
      wb_write = 1'b1; wb_reg = 5'd4; wb_data = 32'h55;
      cyc();
      wb_write = 1'b0;
      cyc();
      chk("stall refresh ex_b", 64'(b_m), 64'h55);
      chk("stall hold ex_a", 64'(a_m), 64'd11);
      chk("stall hold ex_pc", 64'(pc_m), 64'h100);
      chk("stall hold ex_ctrl", 64'(c_m), 64'hABC);
      chk("stall hold ex_rt", 64'(rt_m), 64'd4);
      chk("stall_cnt after 3", 64'(sc_m), 64'd3);
      chk("flush_cnt during stall", 64'(fc_m), 64'd0);

      // Flush beats stall
      flush = 1'b1;
      cyc();
      flush = 1'b0;
      chk("flush ex_valid", 64'(v_m), 64'd0);
      chk("flush ex_ctrl", 64'(c_m), 64'd0);
      chk("flush_cnt", 64'(fc_m), 64'd1);
      chk("flush stall_cnt unchanged", 64'(sc_m), 64'd3);

      // Saturation on the 4-bit variant
      repeat (20) cyc();
      chk("sat stall_cnt", 64'(sc_s), 64'd15);
      chk("wide stall_cnt", 64'(sc_m), 64'd23);
      stall = 1'b0;

      // id_valid=0 load is a bubble that does not count as a flush
      idb.id_valid = 1'b0;
      cyc();
      chk("bubble ex_valid", 64'(v_m), 64'd0);
      chk("bubble ex_pc", 64'(pc_m), 64'd0);
      chk("bubble flush_cnt", 64'(fc_m), 64'd1);

      @(negedge clk);
      #1;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
